// File: rtl/iob_bus_arbiter.sv
// Round-robin arbiter sharing one IOb slave port among N_MASTERS requesters.
// One transaction in flight at a time, with a watchdog that ends stalled transactions.
module iob_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS-1:0]           m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]    m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb,
  output logic [DATA_W-1:0]              m_rdata,
  output logic [N_MASTERS-1:0]           m_ready,
  output logic                           s_valid,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [DATA_W-1:0]              s_wdata,
  output logic [DATA_W/8-1:0]            s_wstrb,
  input  logic [DATA_W-1:0]              s_rdata,
  input  logic                           s_ready,
  output logic [N_MASTERS-1:0]           grant,
  output logic                           timeout_err
);

  // state | meaning
  // IDLE  | no owner; arbitrate among m_valid, no slave request issued
  // BUSY  | grant holds the owner; its request is forwarded to the slave

  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(N_MASTERS);
  localparam int CW = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam bit WD_EN = (TIMEOUT_W > 0);
  localparam logic [PW-1:0] LAST = PW'(N_MASTERS - 1);
  localparam logic [PW:0] NM = (PW+1)'(N_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] win;
  logic [PW-1:0] next_ptr;
  logic [PW:0]   rr_sum;
  logic          win_found;
  logic [CW-1:0] wd_cnt;
  logic          busy;
  logic          owner_valid;
  logic          wd_max;
  logic          done;
  logic          tmo;
  logic          abandon;

  // Circular search upward from ptr; the first requester found wins.
  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    rr_sum    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      rr_sum = {1'b0, ptr} + (PW+1)'(i);
      if (rr_sum >= NM) rr_sum = rr_sum - NM;
      if (!win_found && m_valid[rr_sum[PW-1:0]]) begin
        win       = rr_sum[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  assign busy        = (state == BUSY);
  assign owner_valid = m_valid[gidx];
  assign wd_max      = WD_EN && (wd_cnt == '1);
  assign done        = busy && owner_valid && s_ready;
  // A response landing on the same cycle as the watchdog limit wins over the timeout.
  assign tmo         = busy && owner_valid && !s_ready && wd_max;
  assign abandon     = busy && !owner_valid;
  assign next_ptr    = (gidx == LAST) ? '0 : gidx + 1'b1;

  assign s_valid     = busy && owner_valid && !tmo;
  assign s_addr      = busy ? m_addr[gidx*ADDR_W +: ADDR_W]  : '0;
  assign s_wdata     = busy ? m_wdata[gidx*DATA_W +: DATA_W] : '0;
  assign s_wstrb     = busy ? m_wstrb[gidx*SW +: SW]         : '0;
  assign m_ready     = (done || tmo) ? grant : '0;
  assign m_rdata     = tmo ? '1 : s_rdata;
  assign timeout_err = tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      gidx   <= '0;
      ptr    <= '0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_valid) begin
            state  <= BUSY;
            gidx   <= win;
            grant  <= {{(N_MASTERS-1){1'b0}}, 1'b1} << win;
            wd_cnt <= '0;
          end
        end
        BUSY: begin
          if (done || tmo || abandon) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= next_ptr;
          end else if (WD_EN) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Bench for iob_bus_arbiter: directed scenarios plus randomized traffic checked
// against a round-robin reference computed from the pending-request set.
module tb_iob_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      valid;
  logic [AW-1:0]     addr_a  [N];
  logic [DW-1:0]     wdata_a [N];
  logic [DW/8-1:0]   strb_a  [N];
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_ready;
  logic              s_valid;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_wstrb;
  logic [DW-1:0]     s_rdata;
  logic              s_ready;
  logic [N-1:0]      grant;
  logic              timeout_err;

  int total = 0;
  int bad   = 0;
  int ptr_m;
  int w;

  always #5 clk = ~clk;

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]         = addr_a[i];
      m_wdata[i*DW +: DW]        = wdata_a[i];
      m_wstrb[i*DW/8 +: DW/8]    = strb_a[i];
    end
  end

  iob_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i);
    valid[i]   = 1'b1;
    addr_a[i]  = $urandom;
    wdata_a[i] = $urandom;
    strb_a[i]  = 4'($urandom);
  endtask

  // Reference arbitration: first pending master at or after p, wrapping.
  function automatic int rr_model(input int p, input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    valid   = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_s_addr", s_addr, 0);
    cyc();
    rst = 1'b0;
  endtask

  // Entered in an IDLE cycle with requests already presented; ends in the following IDLE cycle.
  task automatic xact(input int wm, input int lat, input logic [DW-1:0] rd);
    logic [N-1:0] oh;
    oh = N'(1) << wm;
    cyc();
    chk("grant", grant, oh);
    chk("s_valid", s_valid, 1);
    chk("s_addr", s_addr, addr_a[wm]);
    chk("s_wdata", s_wdata, wdata_a[wm]);
    chk("s_wstrb", s_wstrb, strb_a[wm]);
    for (int k = 0; k < lat; k++) begin
      chk("early_m_ready", m_ready, 0);
      cyc();
    end
    s_ready = 1'b1;
    s_rdata = rd;
    #1;
    chk("m_ready", m_ready, oh);
    chk("m_rdata", m_rdata, rd);
    chk("no_timeout_err", timeout_err, 0);
    cyc();
    s_ready   = 1'b0;
    s_rdata   = '0;
    valid[wm] = 1'b0;
    #1;
    chk("idle_grant", grant, 0);
    chk("idle_m_ready", m_ready, 0);
    chk("idle_s_valid", s_valid, 0);
    chk("idle_s_addr", s_addr, 0);
  endtask

  initial begin
    valid   = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = '0;
      wdata_a[i] = '0;
      strb_a[i]  = '0;
    end
    #1;
    do_reset();

    // single master read
    addr_a[0] = 32'h100; wdata_a[0] = '0; strb_a[0] = '0; valid[0] = 1'b1;
    #1;
    chk("arb_latency_s_valid", s_valid, 0);
    xact(0, 3, 32'hCAFEF00D);

    // contention from reset: 0,1,0,1
    do_reset();
    set_req(0); set_req(1);
    xact(0, 1, $urandom);
    set_req(0);
    xact(1, 2, $urandom);
    set_req(1);
    xact(0, 0, $urandom);
    set_req(0);
    xact(1, 1, $urandom);

    // write routing from master 1
    do_reset();
    addr_a[1] = 32'h2004; wdata_a[1] = 32'h11223344; strb_a[1] = 4'hC; valid[1] = 1'b1;
    xact(1, 2, $urandom);

    // wrap: pointer at 2, requests from 0 and 1
    do_reset();
    set_req(1);
    xact(1, 0, $urandom);
    set_req(0); set_req(1);
    xact(0, 1, $urandom);

    // watchdog timeout
    do_reset();
    set_req(2); strb_a[2] = '0;
    cyc();
    chk("to_grant", grant, 3'b100);
    for (int k = 0; k < 15; k++) begin
      chk("to_quiet", {m_ready, timeout_err}, 0);
      cyc();
    end
    chk("to_m_ready", m_ready, 3'b100);
    chk("to_m_rdata", m_rdata, 32'hFFFFFFFF);
    chk("to_err", timeout_err, 1);
    chk("to_s_valid", s_valid, 0);
    cyc();
    valid[2] = 1'b0;
    #1;
    chk("to_grant_after", grant, 0);
    chk("to_err_once", timeout_err, 0);
    s_ready = 1'b1;
    s_rdata = 32'h5555AAAA;
    #1;
    chk("late_ready_ignored", m_ready, 0);
    cyc();
    s_ready = 1'b0;

    // s_ready on the watchdog limit cycle
    do_reset();
    set_req(2);
    cyc();
    for (int k = 0; k < 15; k++) cyc();
    s_ready = 1'b1;
    s_rdata = 32'h12345678;
    #1;
    chk("tie_m_ready", m_ready, 3'b100);
    chk("tie_m_rdata", m_rdata, 32'h12345678);
    chk("tie_no_err", timeout_err, 0);
    cyc();
    s_ready = 1'b0;
    valid[2] = 1'b0;
    #1;
    chk("tie_grant_after", grant, 0);

    // async reset while busy
    do_reset();
    set_req(0);
    cyc();
    chk("busy_grant", grant, 3'b001);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", grant, 0);
    chk("async_rst_s_valid", s_valid, 0);
    chk("async_rst_s_addr", s_addr, 0);
    chk("async_rst_m_ready", m_ready, 0);
    valid = '0;
    cyc();
    rst = 1'b0;

    // randomized traffic against the reference arbitration order
    do_reset();
    ptr_m = 0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid[i] && ($urandom_range(1, 0) == 1)) set_req(i);
      end
      if (valid == '0) set_req($urandom_range(N - 1, 0));
      w = rr_model(ptr_m, valid);
      xact(w, $urandom_range(4, 0), $urandom);
      ptr_m = (w + 1) % N;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
